// File: rtl/uart_rx_fifo.sv
// UART receiver: 16x oversampled frame decoder with start/parity/stop checking,
// feeding a first-word-fall-through byte FIFO with sticky error reporting.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_en,
  input  logic              rx,
  input  logic              rd_en,
  input  logic              err_clr,
  output logic [7:0]        data_out,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HI
  } state_t;

  localparam logic [2:0]      LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic            PAR_INIT  = 1'(PARITY_ODD);
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Input synchroniser (idles high so reset never looks like a start bit)
  // ---------------------------------------------------------------------------
  logic rx_meta;
  logic rx_sync;

  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame decoder
  // ---------------------------------------------------------------------------
  state_t      state;
  state_t      state_nxt;
  logic [3:0]  tick_cnt;
  logic [3:0]  tick_nxt;
  logic [2:0]  bit_cnt;
  logic [2:0]  bit_nxt;
  logic [7:0]  shift_reg;
  logic [7:0]  shift_nxt;
  logic        par_bad;
  logic        par_bad_nxt;
  logic        byte_done;
  logic        set_frame;
  logic        set_parity;
  logic        exp_par;

  // Bits above DATA_BITS are never written, so they stay zero and drop out.
  assign exp_par = (^shift_reg) ^ PAR_INIT;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bad   <= 1'b0;
    end else begin
      state     <= state_nxt;
      tick_cnt  <= tick_nxt;
      bit_cnt   <= bit_nxt;
      shift_reg <= shift_nxt;
      par_bad   <= par_bad_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    state_nxt   = state;
    tick_nxt    = tick_cnt;
    bit_nxt     = bit_cnt;
    shift_nxt   = shift_reg;
    par_bad_nxt = par_bad;
    byte_done   = 1'b0;
    set_frame   = 1'b0;
    set_parity  = 1'b0;

    if (rx_en) begin
      tick_nxt = tick_cnt + 4'd1;
      unique case (state)
        S_IDLE: begin
          tick_nxt = '0;
          if (!rx_sync) state_nxt = S_START;
        end
        S_START: begin
          if (tick_cnt == 4'd7) begin
            tick_nxt    = '0;
            bit_nxt     = '0;
            par_bad_nxt = 1'b0;
            state_nxt   = rx_sync ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (tick_cnt == 4'd15) begin
            shift_nxt[bit_cnt] = rx_sync;
            bit_nxt            = bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (tick_cnt == 4'd15) begin
            par_bad_nxt = (rx_sync != exp_par);
            state_nxt   = S_STOP;
          end
        end
        S_STOP: begin
          if (tick_cnt == 4'd15) begin
            if (rx_sync) begin
              state_nxt = S_IDLE;
              if (par_bad) set_parity = 1'b1;
              else         byte_done  = 1'b1;
            end else begin
              // A low stop bit wins over any parity complaint for this frame.
              set_frame = 1'b1;
              state_nxt = S_WAIT_HI;
            end
          end
        end
        S_WAIT_HI: begin
          tick_nxt = '0;
          if (rx_sync) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FWFT FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_pop;
  logic              do_push;
  logic              drop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign do_pop  = rd_en && !empty;
  // A pop in the same cycle frees the slot the incoming byte needs.
  assign do_push = byte_done && (!full || do_pop);
  assign drop    = byte_done && full && !rd_en;

  assign data_out = empty ? 8'h00 : mem[rd_ptr];

  // NOTE: the storage array has no reset; empty gates data_out, so stale
  // contents are never observable and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shift_reg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (ADDR_W + 1)'(1);
        2'b01:   count <= count - (ADDR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags: a set event in the same cycle beats err_clr
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= set_frame  | (frame_err  & ~err_clr);
      parity_err <= set_parity | (parity_err & ~err_clr);
      overrun    <= drop       | (overrun    & ~err_clr);
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: drives 8E1 frames at 16 clk per tick and
// checks popped bytes against a scoreboard queue plus direct status checks.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_en;
  logic       rx;
  logic       rd_en;
  logic       err_clr;
  logic [7:0] data_out;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DATA_BITS (8),
    .PARITY_EN (1),
    .PARITY_ODD(0),
    .FIFO_DEPTH(8),
    .ADDR_W    (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_en     (rx_en),
    .rx        (rx),
    .rd_en     (rd_en),
    .err_clr   (err_clr),
    .data_out  (data_out),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic expect_outs(input string tag, input logic e, input logic f, input logic [3:0] c,
                             input logic fe, input logic pe, input logic ov);
    check({tag, "_empty"},      32'(empty),      32'(e));
    check({tag, "_full"},       32'(full),       32'(f));
    check({tag, "_count"},      32'(count),      32'(c));
    check({tag, "_frame_err"},  32'(frame_err),  32'(fe));
    check({tag, "_parity_err"}, 32'(parity_err), 32'(pe));
    check({tag, "_overrun"},    32'(overrun),    32'(ov));
  endtask

  // Scoreboard monitor: every accepted pop must match the oldest expected byte.
  always @(negedge clk) begin
    if (!reset && rd_en && !empty) begin
      check("pop_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("pop_data", 32'(data_out), 32'(exp_q.pop_front()));
    end
  end

  // One 16x sample tick: 15 idle clocks then a single rx_en clock.
  task automatic tick(input logic rd);
    repeat (15) @(posedge clk);
    #1 rx_en = 1'b1;
    rd_en = rd;
    @(posedge clk);
    #1 rx_en = 1'b0;
    rd_en = 1'b0;
  endtask

  // rd_tick (1..16) asserts rd_en on that tick edge of the bit; 0 = never.
  task automatic send_bit(input logic b, input int rd_tick);
    rx = b;
    for (int t = 1; t <= 16; t++) tick(t == rd_tick);
  endtask

  // The receiver samples the stop bit on its 9th tick.
  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_b,
                            input int rd_tick_in_stop);
    send_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) send_bit(d[i], 0);
    send_bit((^d) ^ par_flip, 0);
    send_bit(stop_b, rd_tick_in_stop);
  endtask

  task automatic idle_ticks(input int n);
    rx = 1'b1;
    repeat (n) tick(1'b0);
  endtask

  task automatic pop();
    @(posedge clk);
    #1 rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rx      = 1'b1;
    rx_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    reset   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    expect_outs("reset", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    check("reset_data_out", 32'(data_out), 32'h00);
    @(posedge clk);
    #1 reset = 1'b0;

    // 8E1 0xA5, parity bit 0
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    @(negedge clk);
    expect_outs("a5", 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
    check("a5_head", 32'(data_out), 32'hA5);
    pop();
    @(negedge clk);
    expect_outs("a5_read", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // 4-tick glitch must not start a frame, then 0x3C
    rx = 1'b0;
    repeat (4) tick(1'b0);
    idle_ticks(16);
    @(negedge clk);
    expect_outs("glitch", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b0, 1'b1, 0);
    @(negedge clk);
    expect_outs("3c", 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
    check("3c_head", 32'(data_out), 32'h3C);
    pop();

    // Bad parity: flag set, byte discarded, err_clr clears it
    send_frame(8'hA5, 1'b1, 1'b1, 0);
    @(negedge clk);
    expect_outs("par", 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    pulse_clr();
    @(negedge clk);
    check("par_clr", 32'(parity_err), 32'd0);

    // Low stop bit followed by a 40-tick break, then 0x12
    send_frame(8'h55, 1'b0, 1'b0, 0);
    repeat (40) tick(1'b0);
    idle_ticks(16);
    @(negedge clk);
    expect_outs("brk", 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b0, 1'b1, 0);
    @(negedge clk);
    expect_outs("12", 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
    check("12_head", 32'(data_out), 32'h12);
    pop();
    pulse_clr();
    @(negedge clk);
    check("brk_clr", 32'(frame_err), 32'd0);

    // Fill to full, ninth byte overruns
    for (int b = 0; b < 8; b++) begin
      exp_q.push_back(8'(b));
      send_frame(8'(b), 1'b0, 1'b1, 0);
    end
    send_frame(8'h08, 1'b0, 1'b1, 0);
    @(negedge clk);
    expect_outs("full", 1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b1);
    check("full_head", 32'(data_out), 32'h00);
    pulse_clr();
    @(negedge clk);
    check("ovr_clr", 32'(overrun), 32'd0);

    // Push at full coinciding with a pop: no overrun, count holds
    exp_q.push_back(8'h09);
    send_frame(8'h09, 1'b0, 1'b1, 9);
    @(negedge clk);
    expect_outs("swap", 1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
    check("swap_head", 32'(data_out), 32'h01);
    repeat (7) pop();
    @(negedge clk);
    expect_outs("drain", 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
    check("drain_head", 32'(data_out), 32'h09);

    // Reset in the middle of the data bits of 0xFF
    send_bit(1'b0, 0);
    repeat (3) send_bit(1'b1, 0);
    repeat (5) tick(1'b0);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    expect_outs("mid_rst", 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    check("mid_rst_data_out", 32'(data_out), 32'h00);
    @(posedge clk);
    #1 reset = 1'b0;
    idle_ticks(4);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b0, 1'b1, 0);
    @(negedge clk);
    expect_outs("81", 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
    check("81_head", 32'(data_out), 32'h81);
    pop();
    @(negedge clk);
    check("end_empty", 32'(empty), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
